mult_stream_nch: RTL and testbench

- Signed N-lane AXI-stream multiplier with joined A/B inputs, an elastic pipeline of configurable depth, and per-lane scaling with saturation.
- Successor to the single-lane fixed-format multiplier. Adds lane count, output bit-select with rounding, clipping, a selectable tlast source, and full-rate throughput under arbitrary backpressure.
- Sits between rfnoc stream blocks, e.g. gain/mixer datapaths; feeds the packetizer.

---
 rtl/mult_stream_pkg.sv | 13 +
 rtl/mult_stream_round_clip.sv | 46 ++++
 rtl/mult_stream_nch.sv | 158 +++++++++++++++
 tb/tb_mult_stream_nch.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_stream_pkg.sv
// Shared constants and helpers for the mult_stream_nch multiplier family.
// Selects the p_tlast source and sizes the full-precision product.
package mult_stream_pkg;

    localparam int unsigned LAST_SRC_A  = 0;
    localparam int unsigned LAST_SRC_B  = 1;
    localparam int unsigned LAST_SRC_OR = 2;

    function automatic int unsigned prod_width(int unsigned width_a, int unsigned width_b);
        return width_a + width_b;
    endfunction

endpackage

// File: rtl/mult_stream_round_clip.sv
// Per-lane output scaling: optional round-half-up, arithmetic shift by DROP_LSB, saturate.
// Rounding is enabled by defining MULT_STREAM_ROUND_EN; otherwise the shift truncates (floor).
module mult_stream_round_clip
    import mult_stream_pkg::*;
#(
    parameter int unsigned WIDTH_IN = 43,
    parameter int unsigned WIDTH_P  = 24,
    parameter int unsigned DROP_LSB = 17
) (
    input  logic [WIDTH_IN-1:0] prod_i,
    output logic [WIDTH_P-1:0]  res_o
);

    // One guard bit so the rounding increment can never wrap a positive product.
    localparam int unsigned WidthExt = WIDTH_IN + 1;

`ifdef MULT_STREAM_ROUND_EN
    localparam logic [WidthExt-1:0] RoundAdd =
        (DROP_LSB == 0) ? '0 : WidthExt'(1) << ((DROP_LSB == 0) ? 0 : DROP_LSB - 1);
`endif

    logic signed [WidthExt-1:0]   ext;
    logic signed [WidthExt-1:0]   rnd;
    logic signed [WidthExt-1:0]   shifted;
    logic [WidthExt-WIDTH_P:0]    upper;

    always_comb begin
        ext = {prod_i[WIDTH_IN-1], prod_i};
`ifdef MULT_STREAM_ROUND_EN
        rnd = ext + RoundAdd;
`else
        rnd = ext;
`endif
        shifted = rnd >>> DROP_LSB;
        // In range exactly when every bit from the output sign upwards agrees.
        upper = shifted[WidthExt-1:WIDTH_P-1];
        if ((&upper) || !(|upper)) begin
            res_o = shifted[WIDTH_P-1:0];
        end else if (shifted[WidthExt-1]) begin
            res_o = {1'b1, {(WIDTH_P-1){1'b0}}};
        end else begin
            res_o = {1'b0, {(WIDTH_P-1){1'b1}}};
        end
    end

endmodule

// File: rtl/mult_stream_nch.sv
// Signed N-lane AXI-stream multiplier: joined A/B inputs, elastic LATENCY-stage pipeline,
// per-lane round/shift/saturate. Define MULT_STREAM_ROUND_EN for round-half-up scaling.
module mult_stream_nch
    import mult_stream_pkg::*;
#(
    parameter int unsigned NCH      = 2,
    parameter int unsigned WIDTH_A  = 25,
    parameter int unsigned WIDTH_B  = 18,
    parameter int unsigned WIDTH_P  = 24,
    parameter int unsigned DROP_LSB = 17,
    parameter int unsigned LATENCY  = 4,
    parameter int unsigned LAST_SRC = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCH*WIDTH_A-1:0] a_tdata,
    input  logic                   a_tlast,
    input  logic                   a_tvalid,
    output logic                   a_tready,
    input  logic [NCH*WIDTH_B-1:0] b_tdata,
    input  logic                   b_tlast,
    input  logic                   b_tvalid,
    output logic                   b_tready,
    output logic [NCH*WIDTH_P-1:0] p_tdata,
    output logic                   p_tlast,
    output logic                   p_tvalid,
    input  logic                   p_tready
);

    localparam int unsigned WidthFull = prod_width(WIDTH_A, WIDTH_B);

    logic [LATENCY:1]        v_q, v_d;
    logic [LATENCY:1]        last_q, last_d;
    logic [LATENCY:1]        vin;
    logic [LATENCY:1]        rdy;
    logic [LATENCY:1]        ld;
    logic                    accept;
    logic                    last_sel;

    logic [NCH*WIDTH_A-1:0]  a_q, a_d;
    logic [NCH*WIDTH_B-1:0]  b_q, b_d;
    logic [NCH*WidthFull-1:0] prod_mul;
    logic [NCH*WidthFull-1:0] prod_fin;
    logic [NCH*WIDTH_P-1:0]  clip;
    logic [NCH*WIDTH_P-1:0]  p_q, p_d;

    // Stage k may load when empty or when everything downstream of it can move.
    always_comb begin
        logic r;
        r = p_tready;
        rdy = '0;
        for (int k = LATENCY; k >= 1; k--) begin
            r = ~v_q[k] | r;
            rdy[k] = r;
        end
    end

    assign accept   = a_tvalid & b_tvalid & rdy[1];
    assign a_tready = b_tvalid & rdy[1];
    assign b_tready = a_tvalid & rdy[1];

    always_comb begin
        case (LAST_SRC)
            LAST_SRC_A:  last_sel = a_tlast;
            LAST_SRC_B:  last_sel = b_tlast;
            LAST_SRC_OR: last_sel = a_tlast | b_tlast;
            default:     last_sel = a_tlast | b_tlast;
        endcase
    end

    always_comb begin
        vin    = '0;
        v_d    = v_q;
        last_d = last_q;
        vin[1] = accept;
        for (int k = 2; k <= LATENCY; k++) begin
            vin[k] = v_q[k-1];
        end
        ld = rdy & vin;
        for (int k = 1; k <= LATENCY; k++) begin
            if (rdy[k]) begin
                v_d[k] = vin[k];
            end
        end
        if (ld[1]) begin
            last_d[1] = last_sel;
        end
        for (int k = 2; k <= LATENCY; k++) begin
            if (ld[k]) begin
                last_d[k] = last_q[k-1];
            end
        end
        a_d = ld[1] ? a_tdata : a_q;
        b_d = ld[1] ? b_tdata : b_q;
        p_d = ld[LATENCY] ? clip : p_q;
    end

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        logic signed [WidthFull-1:0] a_ext;
        logic signed [WidthFull-1:0] b_ext;

        assign a_ext = WidthFull'($signed(a_q[i*WIDTH_A +: WIDTH_A]));
        assign b_ext = WidthFull'($signed(b_q[i*WIDTH_B +: WIDTH_B]));
        assign prod_mul[i*WidthFull +: WidthFull] = a_ext * b_ext;

        mult_stream_round_clip #(
            .WIDTH_IN (WidthFull),
            .WIDTH_P  (WIDTH_P),
            .DROP_LSB (DROP_LSB)
        ) u_round_clip (
            .prod_i (prod_fin[i*WidthFull +: WidthFull]),
            .res_o  (clip[i*WIDTH_P +: WIDTH_P])
        );
    end

    // Stage 2 holds the full product; any stages before the output stage only delay it.
    if (LATENCY > 2) begin : g_pipe
        logic [NCH*WidthFull-1:0] prod_q [2:LATENCY-1];
        logic [NCH*WidthFull-1:0] prod_d [2:LATENCY-1];

        always_comb begin
            prod_d[2] = ld[2] ? prod_mul : prod_q[2];
            for (int k = 3; k <= LATENCY - 1; k++) begin
                prod_d[k] = ld[k] ? prod_q[k-1] : prod_q[k];
            end
        end

        always_ff @(posedge clk) begin
            prod_q <= prod_d;
        end

        assign prod_fin = prod_q[LATENCY-1];
    end else begin : g_nopipe
        assign prod_fin = prod_mul;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q    <= '0;
            last_q <= '0;
            p_q    <= '0;
        end else begin
            v_q    <= v_d;
            last_q <= last_d;
            p_q    <= p_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign p_tvalid = v_q[LATENCY];
    assign p_tlast  = last_q[LATENCY];
    assign p_tdata  = p_q;

endmodule

// File: tb/tb_mult_stream_nch.sv
// Self-checking bench for mult_stream_nch: directed corner products, join, full rate,
// random backpressure with tlast, and mid-stream reset, against an arithmetic model.
module tb_mult_stream_nch;

    localparam int unsigned NCH  = 2;
    localparam int unsigned W    = 16;
    localparam int unsigned DROP = 15;
    localparam int unsigned LAT  = 4;
    localparam int unsigned LSRC = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [NCH*W-1:0] a_tdata = '0;
    logic           a_tlast = 1'b0;
    logic           a_tvalid = 1'b0;
    logic           a_tready;
    logic [NCH*W-1:0] b_tdata = '0;
    logic           b_tlast = 1'b0;
    logic           b_tvalid = 1'b0;
    logic           b_tready;
    logic [NCH*W-1:0] p_tdata;
    logic           p_tlast;
    logic           p_tvalid;
    logic           p_tready = 1'b0;

    always #5 clk = ~clk;

    mult_stream_nch #(
        .NCH      (NCH),
        .WIDTH_A  (W),
        .WIDTH_B  (W),
        .WIDTH_P  (W),
        .DROP_LSB (DROP),
        .LATENCY  (LAT),
        .LAST_SRC (LSRC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .a_tdata  (a_tdata),
        .a_tlast  (a_tlast),
        .a_tvalid (a_tvalid),
        .a_tready (a_tready),
        .b_tdata  (b_tdata),
        .b_tlast  (b_tlast),
        .b_tvalid (b_tvalid),
        .b_tready (b_tready),
        .p_tdata  (p_tdata),
        .p_tlast  (p_tlast),
        .p_tvalid (p_tvalid),
        .p_tready (p_tready)
    );

    typedef struct {
        logic [NCH*W-1:0] data;
        logic             last;
        bit               timed;
        longint           t;
    } exp_t;

    exp_t   q[$];
    int     nvec = 0;
    int     nerr = 0;
    longint last_acc_t = 0;

    // Spec arithmetic: exact product, optional +half, floor shift, clip.
    function automatic logic [W-1:0] ref_mul(logic [W-1:0] a, logic [W-1:0] b);
        longint p;
        longint pmax;
        longint pmin;
        pmax = (longint'(1) <<< (W - 1)) - 1;
        pmin = -(longint'(1) <<< (W - 1));
        p = longint'($signed(a)) * longint'($signed(b));
`ifdef MULT_STREAM_ROUND_EN
        p = p + (longint'(1) <<< (DROP - 1));
`endif
        p = p >>> DROP;
        if (p > pmax) p = pmax;
        if (p < pmin) p = pmin;
        return p[W-1:0];
    endfunction

    function automatic logic [W-1:0] rword();
        case ($urandom_range(0, 7))
            0:       return 16'h8000;
            1:       return 16'h7fff;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h, required %0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Called at a negedge: samples just before the next posedge, returns at the next negedge.
    task automatic tick(output bit acc);
        #4;
        acc = a_tvalid && a_tready;
        if (acc) last_acc_t = $time;
        @(negedge clk);
    endtask

    task automatic push_exp(input bit timed, input bit use_lit, input logic [W-1:0] lit0);
        exp_t e;
        for (int i = 0; i < NCH; i++) begin
            e.data[i*W +: W] = ref_mul(a_tdata[i*W +: W], b_tdata[i*W +: W]);
        end
        if (use_lit) e.data[W-1:0] = lit0;
        case (LSRC)
            0:       e.last = a_tlast;
            1:       e.last = b_tlast;
            default: e.last = a_tlast | b_tlast;
        endcase
        e.timed = timed;
        e.t = last_acc_t;
        q.push_back(e);
    endtask

    task automatic send_beat(input logic [NCH*W-1:0] a, input logic [NCH*W-1:0] b,
                             input logic al, input logic bl, input bit timed,
                             input bit use_lit, input logic [W-1:0] lit0, input bit immediate);
        bit acc;
        int waits;
        a_tdata = a; b_tdata = b; a_tlast = al; b_tlast = bl;
        a_tvalid = 1'b1; b_tvalid = 1'b1;
        acc = 1'b0; waits = 0;
        while (!acc && waits < 200) begin
            tick(acc);
            waits++;
        end
        if (!acc) begin
            nvec++; nerr++;
            $display("FAIL handshake_timeout: no accept after %0d cycles, required accept", waits);
        end else begin
            push_exp(timed, use_lit, lit0);
            if (immediate) check("full_rate_wait", 64'(waits), 64'd1);
        end
        a_tvalid = 1'b0; b_tvalid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        int n;
        p_tready = 1'b1; a_tvalid = 1'b0; b_tvalid = 1'b0;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            tick(acc);
            n++;
        end
        check("drain_outstanding", 64'(q.size()), 64'd0);
    endtask

    // Compare process: samples 1 time unit before every rising edge.
    initial begin : monitor
        exp_t        e;
        bit          hold_prev;
        logic [NCH*W-1:0] d_prev;
        logic        l_prev;
        hold_prev = 1'b0; d_prev = '0; l_prev = 1'b0;
        forever begin
            @(negedge clk);
            #4;
            if (!reset) begin
                hold_prev = 1'b0;
            end else begin
                check("a_ready_without_b_valid", 64'(a_tready & ~b_tvalid), 64'd0);
                check("b_ready_without_a_valid", 64'(b_tready & ~a_tvalid), 64'd0);
                if (p_tready) check("ready_at_full_rate", 64'(a_tready), 64'(b_tvalid));
                if (hold_prev) begin
                    check("hold_tvalid", 64'(p_tvalid), 64'd1);
                    check("hold_tdata", 64'(p_tdata), 64'(d_prev));
                    check("hold_tlast", 64'(p_tlast), 64'(l_prev));
                end
                if (p_tvalid && p_tready) begin
                    if (q.size() == 0) begin
                        nvec++; nerr++;
                        $display("FAIL spurious_output: got beat %0h, required no beat", p_tdata);
                    end else begin
                        e = q.pop_front();
                        check("p_tdata", 64'(p_tdata), 64'(e.data));
                        check("p_tlast", 64'(p_tlast), 64'(e.last));
                        if (e.timed) check("latency_cycles", 64'(($time - e.t) / 10), 64'(LAT));
                    end
                end
                hold_prev = p_tvalid & ~p_tready;
                d_prev = p_tdata;
                l_prev = p_tlast;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [W-1:0]     da [5];
        logic [W-1:0]     db [5];
        logic [W-1:0]     dl [5];
        logic [NCH*W-1:0] av;
        logic [NCH*W-1:0] bv;
        bit               acc;
        bit               ap;
        bit               bp;
        int               idx;
        int               guard;
        int               sel;

        da = '{16'h4000, 16'h8000, 16'h7fff, 16'h0001, 16'hffff};
        db = '{16'h4000, 16'h8000, 16'h8000, 16'h4000, 16'h4000};
`ifdef MULT_STREAM_ROUND_EN
        dl = '{16'h2000, 16'h7fff, 16'h8001, 16'h0001, 16'h0000};
`else
        dl = '{16'h2000, 16'h7fff, 16'h8001, 16'h0000, 16'hffff};
`endif

        repeat (3) @(negedge clk);
        reset = 1'b1;
        check("reset_tvalid", 64'(p_tvalid), 64'd0);
        check("reset_tdata", 64'(p_tdata), 64'd0);
        check("reset_tlast", 64'(p_tlast), 64'd0);
        @(negedge clk);
        p_tready = 1'b1;

        // Corner products on lane 0, random lane 1, back to back.
        for (int i = 0; i < 5; i++) begin
            send_beat({rword(), da[i]}, {rword(), db[i]}, (i == 2), (i == 4), 1'b1, 1'b1,
                      dl[i], 1'b1);
        end
        drain();

        // A waits alone for 10 cycles, then 0..19 ramps stream at full rate.
        a_tdata = '0; a_tvalid = 1'b1; b_tvalid = 1'b0;
        repeat (10) begin
            tick(acc);
            check("join_no_accept", 64'(acc), 64'd0);
        end
        for (int i = 0; i < 20; i++) begin
            av = {W'(i * 256), W'(i)};
            send_beat(av, av, 1'b0, (i == 19), 1'b1, 1'b0, '0, 1'b1);
        end
        drain();

        // Random valids and backpressure, tlast every 8 beats from either side.
        idx = 0; guard = 0; ap = 1'b0; bp = 1'b0;
        while (idx < 1000 && guard < 20000) begin
            guard++;
            p_tready = 1'($urandom_range(0, 1));
            if (!ap && $urandom_range(0, 3) != 0) begin
                ap = 1'b1;
                for (int i = 0; i < NCH; i++) a_tdata[i*W +: W] = rword();
                sel = (idx % 8 == 7) ? int'($urandom_range(0, 2)) : -1;
                a_tlast = (sel == 0) || (sel == 2);
            end
            if (!bp && $urandom_range(0, 3) != 0) begin
                bp = 1'b1;
                for (int i = 0; i < NCH; i++) b_tdata[i*W +: W] = rword();
                sel = (idx % 8 == 7) ? int'($urandom_range(0, 2)) : -1;
                b_tlast = (sel == 1) || (sel == 2);
            end
            a_tvalid = ap; b_tvalid = bp;
            tick(acc);
            if (acc) begin
                push_exp(1'b0, 1'b0, '0);
                idx++;
                ap = 1'b0; bp = 1'b0;
            end
        end
        check("random_beats_accepted", 64'(idx), 64'd1000);
        a_tlast = 1'b0; b_tlast = 1'b0;
        drain();

        // Three beats stuck behind backpressure, then asynchronous reset mid-cycle.
        p_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < NCH; j++) begin
                av[j*W +: W] = rword();
                bv[j*W +: W] = rword();
            end
            send_beat(av, bv, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        end
        tick(acc);
        check("inflight_tvalid", 64'(p_tvalid), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_tvalid", 64'(p_tvalid), 64'd0);
        check("async_reset_tdata", 64'(p_tdata), 64'd0);
        check("async_reset_tlast", 64'(p_tlast), 64'd0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        p_tready = 1'b1;
        repeat (3) tick(acc);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < NCH; j++) begin
                av[j*W +: W] = rword();
                bv[j*W +: W] = rword();
            end
            send_beat(av, bv, 1'b0, (i == 3), 1'b1, 1'b0, '0, 1'b1);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
